test_run_controller: RTL and testbench

- Synthesizable sequencer for a simulation test harness run.
- Holds the harness in reset for a fixed number of cycles, then counts run cycles.
- Gates the waveform-dump window and merges pass/fail reports from several harness sources into one verdict.
- Issues a finish request with an acknowledge handshake, so a plain testbench or a UVM environment can end the run.

---
 rtl/test_ctrl_pkg.sv | 31 +++
 rtl/sat_cycle_counter.sv | 31 +++
 rtl/test_run_controller.sv | 114 +++++++++++
 tb/tb_test_run_controller.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/test_ctrl_pkg.sv
// Shared types and helpers for the test run controller: FSM states,
// fail_code encodings and a lowest-set-bit priority helper.
package test_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_HOLD  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PASS  = 3'd2,
    ST_FAIL  = 3'd3,
    ST_ACKED = 3'd4
  } state_e;

  localparam int FAIL_NONE = 0;
  localparam int MAX_SRC   = 32;

  // Timeout code sits one past the last per-source code.
  function automatic int fail_timeout(input int num_src);
    return num_src + 1;
  endfunction

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic int lowest_set_idx(input logic [MAX_SRC-1:0] v);
    int idx;
    idx = 0;
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/sat_cycle_counter.sv
// Saturating up-counter with an equality compare against a static value.
module sat_cycle_counter #(
  parameter int CNT_W = 64
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic [CNT_W-1:0] cmp_val,
  output logic [CNT_W-1:0] count,
  output logic             cmp_eq
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             at_max;

  assign at_max = &count_q;

  always_comb begin
    count_d = count_q;
    if (en && !at_max) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count  = count_q;
  assign cmp_eq = (count_q == cmp_val);

endmodule

// File: rtl/test_run_controller.sv
// Harness run sequencer: reset hold, run-cycle counting, dump window,
// pass/fail verdict merge and a finish request/acknowledge handshake.
module test_run_controller
  import test_ctrl_pkg::*;
#(
  parameter  int NUM_SRC    = 2,
  parameter  int CNT_W      = 64,
  parameter  int RST_CYCLES = 8,
  localparam int CODE_W     = $clog2(NUM_SRC + 2)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [CNT_W-1:0]   cfg_max_cycles,
  input  logic [CNT_W-1:0]   cfg_dump_start,
  input  logic [NUM_SRC-1:0] src_success,
  input  logic [NUM_SRC-1:0] src_failure,
  input  logic               finish_ack,
  output logic               harness_reset,
  output logic               dump_en,
  output logic [CNT_W-1:0]   cycle_count,
  output logic               done,
  output logic               passed,
  output logic [CODE_W-1:0]  fail_code,
  output logic               finish_req
);

  state_e             state_q, state_d;
  logic [CODE_W-1:0]  fail_code_q, fail_code_d;
  logic [NUM_SRC-1:0] sticky_q, sticky_d;
  logic               dump_en_q, dump_en_d;

  logic [CNT_W-1:0]   cnt;
  logic               dump_hit;
  logic               fail_any, timeout_hit, all_success;
  logic               pre_verdict, verdict_entry;

  sat_cycle_counter #(.CNT_W(CNT_W)) u_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (state_q != ST_ACKED),
    .cmp_val (cfg_dump_start),
    .count   (cnt),
    .cmp_eq  (dump_hit)
  );

  // cycle_count + 1 > max is the same as cycle_count >= max, without overflow.
  assign fail_any    = |src_failure;
  assign timeout_hit = (cfg_max_cycles != '0) && (cnt >= cfg_max_cycles);
  assign all_success = &(sticky_q | src_success);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_HOLD;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_HOLD:  if (cnt == CNT_W'(RST_CYCLES - 1)) state_d = ST_RUN;
      ST_RUN: begin
        if (fail_any || timeout_hit) state_d = ST_FAIL;
        else if (all_success)        state_d = ST_PASS;
      end
      ST_PASS, ST_FAIL: if (finish_ack) state_d = ST_ACKED;
      ST_ACKED: state_d = ST_ACKED;
      default:  state_d = ST_HOLD;
    endcase
  end

  assign pre_verdict   = (state_q == ST_HOLD) || (state_q == ST_RUN);
  assign verdict_entry = pre_verdict && ((state_d == ST_PASS) || (state_d == ST_FAIL));

  always_comb begin
    fail_code_d = fail_code_q;
    sticky_d    = sticky_q;
    dump_en_d   = dump_en_q;
    if (state_q == ST_RUN) begin
      sticky_d = sticky_q | src_success;
      if (fail_any)
        fail_code_d = CODE_W'(lowest_set_idx(MAX_SRC'(src_failure)) + 1);
      else if (timeout_hit)
        fail_code_d = CODE_W'(fail_timeout(NUM_SRC));
    end
    // Verdict entry closes the window even if the start cycle lands on it.
    if (verdict_entry)               dump_en_d = 1'b0;
    else if (pre_verdict && dump_hit) dump_en_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fail_code_q <= CODE_W'(FAIL_NONE);
      sticky_q    <= '0;
      dump_en_q   <= 1'b0;
    end else begin
      fail_code_q <= fail_code_d;
      sticky_q    <= sticky_d;
      dump_en_q   <= dump_en_d;
    end
  end

  // PASS always carries FAIL_NONE, so ACKED recovers the verdict from the code.
  always_comb begin
    harness_reset = (state_q == ST_HOLD);
    finish_req    = (state_q == ST_PASS) || (state_q == ST_FAIL);
    done          = finish_req || (state_q == ST_ACKED);
    passed        = (state_q == ST_PASS) ||
                    ((state_q == ST_ACKED) && (fail_code_q == CODE_W'(FAIL_NONE)));
  end

  assign fail_code   = fail_code_q;
  assign dump_en     = dump_en_q;
  assign cycle_count = cnt;

endmodule

// File: tb/tb_test_run_controller.sv
// Directed bench: verdicts checked by a scoreboard monitor on each done rise,
// control/dump/handshake behaviour by point checks.
module tb_test_run_controller;

  localparam longint unsigned NEVER = 64'hFFFF_FFFF;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] cfg_max_cycles = '0;
  logic [63:0] cfg_dump_start = NEVER;
  logic [1:0]  src_success = '0;
  logic [1:0]  src_failure = '0;
  logic        finish_ack = 1'b0;
  logic        harness_reset, dump_en, done, passed, finish_req;
  logic [63:0] cycle_count;
  logic [1:0]  fail_code;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        passed;
    logic [1:0]  code;
    logic [63:0] cnt;
  } exp_t;
  exp_t exp_q[$];

  test_run_controller dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .cfg_max_cycles (cfg_max_cycles),
    .cfg_dump_start (cfg_dump_start),
    .src_success    (src_success),
    .src_failure    (src_failure),
    .finish_ack     (finish_ack),
    .harness_reset  (harness_reset),
    .dump_en        (dump_en),
    .cycle_count    (cycle_count),
    .done           (done),
    .passed         (passed),
    .fail_code      (fail_code),
    .finish_req     (finish_req)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every new verdict must match the oldest expectation.
  logic done_d = 1'b0;
  always @(negedge clock) begin
    if (reset_n && done && !done_d) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_verdict", 64'(done), 64'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_passed", 64'(passed), 64'(e.passed));
        chk("sb_fail_code", 64'(fail_code), 64'(e.code));
        chk("sb_cycle_count", cycle_count, e.cnt);
      end
    end
    done_d = done;
  end

  task automatic push_exp(input logic p, input logic [1:0] c, input logic [63:0] n);
    exp_t e;
    e.passed = p; e.code = c; e.cnt = n;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_harness_reset"}, 64'(harness_reset), 64'(1));
    chk({tag, "_cycle_count"}, cycle_count, 64'(0));
    chk({tag, "_dump_en"}, 64'(dump_en), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_passed"}, 64'(passed), 64'(0));
    chk({tag, "_fail_code"}, 64'(fail_code), 64'(0));
    chk({tag, "_finish_req"}, 64'(finish_req), 64'(0));
  endtask

  task automatic do_reset(input logic [63:0] max_c, input logic [63:0] dstart);
    @(negedge clock);
    src_success = '0; src_failure = '0; finish_ack = 1'b0;
    reset_n = 1'b0;
    cfg_max_cycles = max_c;
    cfg_dump_start = dstart;
    #1 check_reset_vals("reset");
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Returns at the negedge where cycle_count == n; inputs driven then are
  // sampled on the edge whose pre-edge count is n.
  task automatic wait_count(input logic [63:0] n);
    int k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (cycle_count != n && k < 3000);
    if (cycle_count != n) chk("wait_count_timeout", cycle_count, n);
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 1000) begin
      @(negedge clock);
      k++;
    end
    chk("wait_done", 64'(done), 64'(1));
  endtask

  task automatic pulse(input logic [1:0] s, input logic [1:0] f);
    src_success = s; src_failure = f;
    @(negedge clock);
    src_success = '0; src_failure = '0;
  endtask

  task automatic ack_and_check_frozen(input string tag);
    logic [63:0] snap;
    finish_ack = 1'b1;
    @(negedge clock);
    finish_ack = 1'b0;
    chk({tag, "_finish_req_dropped"}, 64'(finish_req), 64'(0));
    chk({tag, "_done_held"}, 64'(done), 64'(1));
    snap = cycle_count;
    repeat (4) @(negedge clock);
    chk({tag, "_count_frozen"}, cycle_count, snap);
  endtask

  initial begin
    // Pass path: success[0] at 20, success[1] at 30.
    do_reset(64'd0, NEVER);
    wait_count(7);
    chk("t1_hold_at7", 64'(harness_reset), 64'(1));
    wait_count(8);
    chk("t1_run_at8", 64'(harness_reset), 64'(0));
    wait_count(20);
    pulse(2'b01, 2'b00);
    wait_count(30);
    chk("t1_not_done_at30", 64'(done), 64'(0));
    push_exp(1'b1, 2'd0, 64'd31);
    pulse(2'b10, 2'b00);
    chk("t1_finish_req", 64'(finish_req), 64'(1));
    chk("t1_dump_never", 64'(dump_en), 64'(0));
    ack_and_check_frozen("t1");
    chk("t1_passed_held", 64'(passed), 64'(1));

    // Timeout at cfg_max_cycles = 100.
    do_reset(64'd100, NEVER);
    wait_count(100);
    chk("t2_not_done_at100", 64'(done), 64'(0));
    push_exp(1'b0, 2'd3, 64'd101);
    wait_done();
    repeat (5) @(negedge clock);
    chk("t2_finish_req_held", 64'(finish_req), 64'(1));
    chk("t2_fail_code_held", 64'(fail_code), 64'(3));
    ack_and_check_frozen("t2");
    chk("t2_passed_low", 64'(passed), 64'(0));

    // Simultaneous failure and success on both sources.
    do_reset(64'd0, NEVER);
    wait_count(12);
    push_exp(1'b0, 2'd1, 64'd13);
    pulse(2'b11, 2'b11);
    chk("t3_finish_req", 64'(finish_req), 64'(1));

    // Failure during HOLD ignored; dump window 50..verdict.
    do_reset(64'd0, 64'd50);
    wait_count(3);
    pulse(2'b00, 2'b10);
    wait_count(9);
    chk("t4_no_verdict", 64'(done), 64'(0));
    chk("t4_in_run", 64'(harness_reset), 64'(0));
    wait_count(50);
    chk("t5_dump_before", 64'(dump_en), 64'(0));
    wait_count(51);
    chk("t5_dump_set", 64'(dump_en), 64'(1));
    wait_count(80);
    chk("t5_dump_at80", 64'(dump_en), 64'(1));
    push_exp(1'b1, 2'd0, 64'd81);
    pulse(2'b11, 2'b00);
    chk("t5_dump_cleared", 64'(dump_en), 64'(0));

    // dump_start = 0, then async reset mid-run at cycle 40.
    do_reset(64'd0, 64'd0);
    wait_count(1);
    chk("t5_dump_first_edge", 64'(dump_en), 64'(1));
    wait_count(20);
    pulse(2'b01, 2'b00);
    wait_count(40);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("async");
    @(negedge clock);
    reset_n = 1'b1;
    wait_count(7);
    chk("t6_hold_at7", 64'(harness_reset), 64'(1));
    wait_count(8);
    chk("t6_run_at8", 64'(harness_reset), 64'(0));
    wait_count(15);
    pulse(2'b10, 2'b00);
    wait_count(17);
    chk("t6_sticky_cleared", 64'(done), 64'(0));
    wait_count(20);
    push_exp(1'b1, 2'd0, 64'd21);
    pulse(2'b01, 2'b00);
    repeat (2) @(negedge clock);

    chk("sb_queue_empty", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
